// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op width and encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package usr_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b010;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ASR  = 3'b110;
  localparam logic [OP_W-1:0] OP_SRT  = 3'b111;

endpackage

// File: rtl/universal_shift_reg_srt_cell.sv
// One-bit set/reset/toggle next-state function (the clocked SR cell's logic).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: q_i current bit, s_i set request, r_i reset request, q_next_o next bit.
module srt_cell (
  input  logic q_i,
  input  logic s_i,
  input  logic r_i,
  output logic q_next_o
);

  // s&r toggles instead of being forbidden; s alone sets, r alone clears.
  always_comb begin
    q_next_o = q_i;
    unique case ({s_i, r_i})
      2'b10:   q_next_o = 1'b1;
      2'b01:   q_next_o = 1'b0;
      2'b11:   q_next_o = ~q_i;
      default: q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, load, shifts, rotates, per-bit set/reset/toggle.
// Latency: one cycle; all outputs registered and change on the same edge.
// Backpressure: none; en=0 holds every output, op may change every cycle.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en, op          operation enable and select
//   d               parallel load data
//   s_mask, r_mask  per-bit set/reset requests for SRT
//   sin_r, sin_l    serial inputs for SHL (into bit 0) and SHR (into bit WIDTH-1)
//   q, qbar         register contents and its complement
//   sout            last bit shifted or rotated out
//   zero            high when q is all zeros
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] s_mask,
  input  logic [WIDTH-1:0] r_mask,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             zero
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q;
  logic             sout_q, sout_d;
  logic             zero_q;
  logic [WIDTH-1:0] srt_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_srt
    srt_cell u_cell (
      .q_i      (q_q[i]),
      .s_i      (s_mask[i]),
      .r_i      (r_mask[i]),
      .q_next_o (srt_next[i])
    );
  end

  // sout only moves on ops that actually push a bit out of the word.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (en) begin
      case (op)
        OP_LOAD: q_d = d;
        OP_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin_r};
          sout_d = q_q[WIDTH-1];
        end
        OP_SHR: begin
          q_d    = {sin_l, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        OP_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        OP_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        OP_ASR: begin
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        OP_SRT:  q_d = srt_next;
        default: q_d = q_q;
      endcase
    end
  end

  // qbar and zero come from the next-state value so they never lag q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      qbar_q <= ~RST_VAL;
      sout_q <= 1'b0;
      zero_q <= (RST_VAL == {WIDTH{1'b0}});
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
      sout_q <= sout_d;
      zero_q <= (q_d == {WIDTH{1'b0}});
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign sout = sout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg with two instances (RST_VAL 00 and 3C).
// Latency: each step drives inputs, waits one rising edge, samples 1 time unit later.
// Backpressure: n/a.
module tb_universal_shift_reg;
  import usr_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] op;
  logic [7:0] d, s_mask, r_mask;
  logic       sin_r, sin_l;

  logic [7:0] q0, qbar0, q1, qbar1;
  logic       sout0, zero0, sout1, zero1;

  int checks = 0;
  int errors = 0;

  universal_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d),
    .s_mask(s_mask), .r_mask(r_mask), .sin_r(sin_r), .sin_l(sin_l),
    .q(q0), .qbar(qbar0), .sout(sout0), .zero(zero0)
  );

  universal_shift_reg #(.WIDTH(8), .RST_VAL(8'h3C)) dut1 (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d),
    .s_mask(s_mask), .r_mask(r_mask), .sin_r(sin_r), .sin_l(sin_l),
    .q(q1), .qbar(qbar1), .sout(sout1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] dd);
    en = e;
    op = o;
    d  = dd;
    @(posedge clk);
    #1;
  endtask

  // Checks q, qbar, sout and zero of dut0 together.
  task automatic chk0(input string tag, input logic [7:0] eq, input logic es, input logic ez);
    chk({tag, ".q"}, q0, eq);
    chk({tag, ".qbar"}, qbar0, ~eq);
    chk({tag, ".sout"}, {7'd0, sout0}, {7'd0, es});
    chk({tag, ".zero"}, {7'd0, zero0}, {7'd0, ez});
  endtask

  initial begin
    logic [7:0] exp_q;
    rst = 1'b1; en = 1'b0; op = OP_HOLD; d = 8'h00;
    s_mask = 8'h00; r_mask = 8'h00; sin_r = 1'b0; sin_l = 1'b0;

    // Reset for two cycles
    step(1'b0, OP_HOLD, 8'h00);
    step(1'b0, OP_HOLD, 8'h00);
    chk0("reset", 8'h00, 1'b0, 1'b1);
    chk("reset1.q", q1, 8'h3C);
    chk("reset1.qbar", qbar1, 8'hC3);
    chk("reset1.zero", {7'd0, zero1}, 8'd0);
    rst = 1'b0;

    // en=0 blocks a LOAD
    step(1'b0, OP_LOAD, 8'hA5);
    chk0("en0_load", 8'h00, 1'b0, 1'b1);

    // Load and shifts
    step(1'b1, OP_LOAD, 8'hA5);
    chk0("load_a5", 8'hA5, 1'b0, 1'b0);
    sin_r = 1'b1;
    step(1'b1, OP_SHL, 8'h00);
    chk0("shl", 8'h4B, 1'b1, 1'b0);
    sin_l = 1'b0;
    step(1'b1, OP_SHR, 8'h00);
    chk0("shr", 8'h25, 1'b1, 1'b0);
    step(1'b0, OP_SHL, 8'h00);
    chk0("en0_shl", 8'h25, 1'b1, 1'b0);

    // Rotates
    step(1'b1, OP_LOAD, 8'h81);
    chk0("load_81", 8'h81, 1'b1, 1'b0);
    step(1'b1, OP_ROL, 8'h00);
    chk0("rol1", 8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, OP_ROL, 8'h00);
    chk0("rol8", 8'h81, 1'b1, 1'b0);
    step(1'b1, OP_LOAD, 8'h01);
    step(1'b1, OP_ROR, 8'h00);
    chk0("ror", 8'h80, 1'b1, 1'b0);
    sin_l = 1'b1;
    step(1'b1, OP_SHR, 8'h00);
    chk0("shr_sin1", 8'hC0, 1'b0, 1'b0);

    // ASR saturation from 80
    step(1'b1, OP_LOAD, 8'h80);
    exp_q = 8'h80;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, OP_ASR, 8'h00);
      exp_q = {1'b1, exp_q[7:1]};
      chk("asr.q", q0, exp_q);
      chk("asr.zero", {7'd0, zero0}, 8'd0);
    end
    chk("asr7.q", q0, 8'hFF);
    step(1'b1, OP_ASR, 8'h00);
    chk0("asr8", 8'hFF, 1'b1, 1'b0);

    // SRT set/reset then toggle then hold
    step(1'b1, OP_LOAD, 8'h0F);
    s_mask = 8'hF0; r_mask = 8'h03;
    step(1'b1, OP_SRT, 8'h00);
    chk0("srt", 8'hFC, 1'b1, 1'b0);
    s_mask = 8'hFF; r_mask = 8'hFF;
    step(1'b1, OP_SRT, 8'h00);
    chk0("srt_tog", 8'h03, 1'b1, 1'b0);
    s_mask = 8'h00; r_mask = 8'h00;
    step(1'b1, OP_SRT, 8'h00);
    chk0("srt_hold", 8'h03, 1'b1, 1'b0);

    // Drain FF to zero with SHL
    step(1'b1, OP_LOAD, 8'hFF);
    sin_r = 1'b0;
    exp_q = 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, OP_SHL, 8'h00);
      exp_q = {exp_q[6:0], 1'b0};
      chk0("drain", exp_q, 1'b1, (i == 8));
    end
    step(1'b1, OP_SHL, 8'h00);
    chk0("drain_past", 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a rotate sequence
    step(1'b1, OP_LOAD, 8'h81);
    step(1'b1, OP_ROL, 8'h00);
    chk("mid_rol.q1", q1, 8'h03);
    chk("mid_rol.sout1", {7'd0, sout1}, 8'd1);
    rst = 1'b1;
    step(1'b1, OP_ROL, 8'h00);
    rst = 1'b0;
    chk("midrst.q1", q1, 8'h3C);
    chk("midrst.qbar1", qbar1, 8'hC3);
    chk("midrst.zero1", {7'd0, zero1}, 8'd0);
    chk("midrst.sout1", {7'd0, sout1}, 8'd0);
    chk0("midrst0", 8'h00, 1'b0, 1'b1);
    step(1'b1, OP_ROR, 8'h00);
    chk("after_rst.q1", q1, 8'h1E);
    chk("after_rst.sout1", {7'd0, sout1}, 8'd0);
    step(1'b1, OP_ROR, 8'h00);
    step(1'b1, OP_ROR, 8'h00);
    chk("after_rst3.q1", q1, 8'h87);
    chk("after_rst3.sout1", {7'd0, sout1}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
